// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_bank
//  Description : Bank of N_CH independent programmable clock dividers. Each
//                channel produces a one-cycle tick every D enabled cycles and
//                a 50% square wave that toggles on each tick. A channel runs
//                either periodically or as a one-shot that disarms itself.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 20,
  parameter int DEF_DIV = 100_000,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   i_en,
  input  logic              i_wr_en,
  input  logic [CH_W-1:0]   i_wr_ch,
  input  logic [CNT_W-1:0]  i_wr_div,
  input  logic              i_wr_mode,
  output logic [N_CH-1:0]   o_tick,
  output logic [N_CH-1:0]   o_clk_out,
  output logic [N_CH-1:0]   o_armed
);

  localparam logic [CNT_W-1:0] c_DEF_DIV = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_ZERO    = '0;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    // Channel index in write-select width; indices >= N_CH never match any
    // channel, so out-of-range writes fall through untouched.
    localparam logic [CH_W-1:0] c_IDX = CH_W'(gi);

    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mode;
    logic             r_tick;
    logic             r_clk;
    logic             r_armed;

    logic             w_wr_hit;
    logic             w_run;
    logic             w_term;

    assign w_wr_hit = i_wr_en && (i_wr_ch == c_IDX);
    // A zero divisor halts the channel; it also keeps div-1 from wrapping.
    assign w_run    = i_en[gi] && r_armed && (r_div != c_ZERO);
    // ">=" rather than "==" so a count left above a newly shortened divisor
    // still reaches terminal count on the next enabled edge.
    assign w_term   = (r_cnt >= (r_div - c_ONE));

    // Channel state: reset, then configuration write, then counting.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_div   <= c_DEF_DIV;
        r_mode  <= 1'b0;
        r_cnt   <= c_ZERO;
        r_tick  <= 1'b0;
        r_clk   <= 1'b0;
        r_armed <= 1'b1;
      end else if (w_wr_hit) begin
        r_div   <= i_wr_div;
        r_mode  <= i_wr_mode;
        r_cnt   <= c_ZERO;
        r_tick  <= 1'b0;
        r_clk   <= 1'b0;
        r_armed <= 1'b1;
      end else if (w_run) begin
        if (w_term) begin
          r_cnt  <= c_ZERO;
          r_tick <= 1'b1;
          r_clk  <= ~r_clk;
          if (r_mode) begin
            r_armed <= 1'b0;
          end
        end else begin
          r_cnt  <= r_cnt + c_ONE;
          r_tick <= 1'b0;
        end
      end else begin
        r_tick <= 1'b0;
      end
    end

    assign o_tick[gi]    = r_tick;
    assign o_clk_out[gi] = r_clk;
    assign o_armed[gi]   = r_armed;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_bank
//  Description : Self-checking bench for clk_div_bank. A reference model
//                pushes expected outputs per edge into a scoreboard queue;
//                directed scenarios add tick-count and timing checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

  localparam int c_DEF  = 7;
  localparam int c_DEF5 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [19:0] wr_div;
  logic        wr_mode;
  logic [3:0]  o_tick, o_clk_out, o_armed;

  logic [4:0]  en5;
  logic        wr5_en;
  logic [2:0]  wr5_ch;
  logic [7:0]  wr5_div;
  logic        wr5_mode;
  logic [4:0]  o_tick5, o_clk_out5, o_armed5;

  always #5 clk = ~clk;

  clk_div_bank #(.N_CH(4), .CNT_W(20), .DEF_DIV(c_DEF)) u_dut (
    .clk(clk), .rst(rst), .i_en(en), .i_wr_en(wr_en), .i_wr_ch(wr_ch),
    .i_wr_div(wr_div), .i_wr_mode(wr_mode),
    .o_tick(o_tick), .o_clk_out(o_clk_out), .o_armed(o_armed)
  );

  // Five-channel instance: a 3-bit select can address the nonexistent
  // channels 5..7, which must be ignored.
  clk_div_bank #(.N_CH(5), .CNT_W(8), .DEF_DIV(c_DEF5)) u_dut5 (
    .clk(clk), .rst(rst), .i_en(en5), .i_wr_en(wr5_en), .i_wr_ch(wr5_ch),
    .i_wr_div(wr5_div), .i_wr_mode(wr5_mode),
    .o_tick(o_tick5), .o_clk_out(o_clk_out5), .o_armed(o_armed5)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state for the four-channel instance.
  int         m_div [4];
  int         m_cnt [4];
  logic [3:0] m_mode, m_tick, m_clk, m_arm;

  logic [11:0] q_exp [$];

  int ticks4 [4];
  int ticks5 [5];
  int bad5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 4; i++) ticks4[i] = 0;
    for (int i = 0; i < 5; i++) ticks5[i] = 0;
    bad5 = 0;
  endtask

  // Called at a falling edge with inputs settled: predict the next edge,
  // queue the prediction, then compare it against the DUT after the edge.
  task automatic step();
    logic [11:0] e;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        m_div[i] = c_DEF; m_mode[i] = 1'b0; m_cnt[i] = 0;
        m_tick[i] = 1'b0; m_clk[i] = 1'b0; m_arm[i] = 1'b1;
      end else if (wr_en && (int'(wr_ch) == i)) begin
        m_div[i] = int'(wr_div); m_mode[i] = wr_mode; m_cnt[i] = 0;
        m_tick[i] = 1'b0; m_clk[i] = 1'b0; m_arm[i] = 1'b1;
      end else if (en[i] && m_arm[i] && m_div[i] != 0) begin
        if (m_cnt[i] >= m_div[i] - 1) begin
          m_cnt[i] = 0; m_tick[i] = 1'b1; m_clk[i] = ~m_clk[i];
          if (m_mode[i]) m_arm[i] = 1'b0;
        end else begin
          m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 1'b0;
        end
      end else begin
        m_tick[i] = 1'b0;
      end
    end
    q_exp.push_back({m_tick, m_clk, m_arm});
    @(posedge clk);
    #1;
    e = q_exp.pop_front();
    chk("tick", o_tick, e[11:8]);
    chk("clk_out", o_clk_out, e[7:4]);
    chk("armed", o_armed, e[3:0]);
    for (int i = 0; i < 4; i++) if (o_tick[i]) ticks4[i]++;
    for (int i = 0; i < 5; i++) if (o_tick5[i]) ticks5[i]++;
    if (o_tick5 != 5'h00 && o_tick5 != 5'h1f) bad5++;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wr(input int ch, input int d, input logic mode);
    wr_en = 1'b1; wr_ch = 2'(ch); wr_div = 20'(d); wr_mode = mode;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int first;
    int changed;
    logic c3;

    rst = 1'b1; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_mode = 1'b0;
    en5 = 5'h1f; wr5_en = 1'b0; wr5_ch = '0; wr5_div = '0; wr5_mode = 1'b0;
    m_mode = '0; m_tick = '0; m_clk = '0; m_arm = '1;
    for (int i = 0; i < 4; i++) begin m_div[i] = c_DEF; m_cnt[i] = 0; end
    clear_counts();

    @(negedge clk);
    step();
    chk("reset_tick", o_tick, 4'h0);
    chk("reset_armed", o_armed, 4'hf);
    rst = 1'b0;

    // Periodic divide-by-5 on channel 0.
    en = 4'b0001;
    wr(0, 5, 1'b0);
    clear_counts();
    first = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (o_tick[0] && first < 0) first = k;
    end
    chk("p5_first_edge", first, 5);
    chk("p5_ticks", ticks4[0], 4);
    chk("p5_other_ticks", ticks4[1] + ticks4[2] + ticks4[3], 0);

    // One-shot divide-by-3 on channel 2.
    en = 4'b0101;
    wr(2, 3, 1'b1);
    clear_counts();
    steps(3);
    chk("os_tick", o_tick[2], 1'b1);
    chk("os_armed", o_armed[2], 1'b0);
    chk("os_ticks", ticks4[2], 1);
    clear_counts();
    steps(100);
    chk("os_hold", ticks4[2], 0);
    wr(2, 3, 1'b1);
    chk("os_rearm", o_armed[2], 1'b1);
    clear_counts();
    steps(3);
    chk("os_second", ticks4[2], 1);

    // Enable gap on channel 1 with divisor 4.
    en = 4'b0111;
    wr(1, 4, 1'b0);
    clear_counts();
    steps(2);
    en[1] = 1'b0;
    steps(7);
    en[1] = 1'b1;
    step();
    chk("resume_edge1", o_tick[1], 1'b0);
    step();
    chk("resume_edge2", o_tick[1], 1'b1);
    steps(12);
    chk("en_ticks", ticks4[1], 4);

    // Zero divisor halts channel 3, then divide-by-1.
    en = 4'b1111;
    wr(3, 0, 1'b0);
    clear_counts();
    c3 = o_clk_out[3];
    changed = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (o_clk_out[3] != c3) changed++;
    end
    chk("d0_ticks", ticks4[3], 0);
    chk("d0_clk_changes", changed, 0);
    wr(3, 1, 1'b0);
    clear_counts();
    steps(10);
    chk("d1_ticks", ticks4[3], 10);

    // Write on the terminal-count edge takes priority.
    wr(0, 6, 1'b0);
    steps(5);
    wr(0, 2, 1'b0);
    chk("wr_prio_tick", o_tick[0], 1'b0);
    chk("wr_prio_clk", o_clk_out[0], 1'b0);
    clear_counts();
    steps(6);
    chk("d2_ticks", ticks4[0], 3);

    // Out-of-range writes on the five-channel instance.
    clear_counts();
    wr5_en = 1'b1; wr5_div = 8'd1; wr5_mode = 1'b1;
    wr5_ch = 3'd5; step();
    wr5_ch = 3'd6; step();
    wr5_ch = 3'd7; step();
    wr5_en = 1'b0;
    steps(27);
    for (int i = 0; i < 5; i++) chk($sformatf("oor_ticks%0d", i), ticks5[i], 10);
    chk("oor_phase", bad5, 0);
    chk("oor_armed", o_armed5, 5'h1f);

    // Reset mid-count with a coincident write.
    en = 4'b1111;
    rst = 1'b1; wr_en = 1'b1; wr_ch = 2'd1; wr_div = 20'd2; wr_mode = 1'b0;
    step();
    rst = 1'b0; wr_en = 1'b0;
    chk("rst_tick", o_tick, 4'h0);
    chk("rst_clk", o_clk_out, 4'h0);
    chk("rst_armed", o_armed, 4'hf);
    clear_counts();
    steps(6);
    chk("rst_no_early", ticks4[0] + ticks4[1] + ticks4[2] + ticks4[3], 0);
    step();
    chk("rst_def_tick", o_tick, 4'hf);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      en      = 4'($urandom);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_ch   = 2'($urandom);
      wr_div  = 20'($urandom_range(0, 6));
      wr_mode = 1'($urandom);
      rst     = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter N_CH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 20: width of divisor and counter.
REQ-003 Parameter DEF_DIV, default 100_000: divisor loaded into every channel at reset.
REQ-004 clk  in  1: single system clock; all state on rising edge.
REQ-005 rst  in  1: reset, synchronous, active-high.
REQ-006 en  in  N_CH: per-channel count enable.
REQ-007 wr_en  in  1: configuration write strobe, one cycle per write.
REQ-008 wr_ch  in  max(1,$clog2(N_CH)): target channel index.
REQ-009 wr_div  in  CNT_W: new divisor D.
REQ-010 wr_mode  in  1: 0 = periodic, 1 = one-shot.
REQ-011 tick  out  N_CH: registered one-cycle pulse per channel at terminal count.
REQ-012 clk_out  out  N_CH: registered square wave per channel, toggles at each tick.
REQ-013 armed  out  N_CH: channel is able to produce further ticks.

Function
REQ-014 Each channel SHALL hold div[CNT_W], mode, cnt[CNT_W], armed, tick and clk_out registers; channels are fully independent.
REQ-015 Counting: on an edge with en[i]=1, armed[i]=1, div[i]!=0: if cnt>=div-1 then cnt<=0, tick<=1, clk_out toggles; else cnt<=cnt+1, tick<=0.
REQ-016 The ">=" compare SHALL guarantee recovery from any cnt>=div; no cycle without a terminal count beyond div edges.
REQ-017 Tick period SHALL equal D cycles; clk_out period 2D cycles, 50% duty; D=1 gives tick held high and clk_out = clk/2.
REQ-018 div[i]=0 SHALL halt the channel: cnt holds, tick=0, clk_out holds, armed unchanged.
REQ-019 en[i]=0: cnt and clk_out hold, tick=0 on next edge; counting resumes from held cnt when en returns high.
REQ-020 One-shot (mode=1): the edge producing tick SHALL also clear armed; channel then holds (tick=0, cnt=0, clk_out holds) until rewritten.
REQ-021 Periodic (mode=0): armed SHALL remain 1.
REQ-022 Write: edge with wr_en=1 and wr_ch<N_CH SHALL load div<=wr_div, mode<=wr_mode and set cnt<=0, tick<=0, clk_out<=0, armed<=1 for that channel only.
REQ-023 Write with wr_ch>=N_CH SHALL be ignored with no state change.
REQ-024 Write to channel i SHALL take priority over counting on the same edge; coincident terminal count produces no tick.
REQ-025 Latency: after a write or reset with en held high, first tick SHALL be high in the cycle after the D-th subsequent rising edge.
REQ-026 All outputs SHALL be driven directly from registers; no combinational path from inputs to outputs.

Reset
REQ-027 On an edge with rst=1, every channel SHALL load div=DEF_DIV, mode=0, cnt=0, tick=0, clk_out=0, armed=1.
REQ-028 rst SHALL override wr_en and en on the same edge; reset mid-count discards the partial count.
REQ-029 Outputs before the first reset edge are unspecified; benches SHALL apply rst for at least 1 cycle.

Verification
REQ-030 N_CH=4, reset then en=4'b0001, write ch0 D=5 mode 0 -> tick[0] high for 1 cycle every 5 cycles, first 5 edges after write; clk_out[0] period 10; channels 1-3 tick=0.
REQ-031 Write ch2 D=3 mode 1, en[2]=1 -> exactly one tick[2] on 3rd edge, armed[2] falls the same edge, no further ticks over 100 cycles; rewrite ch2 -> armed[2]=1, one more tick after 3 edges.
REQ-032 ch1 D=4 running, drop en[1] for 7 cycles at cnt=2 -> tick resumes 2 edges after en returns; total ticks match enabled-cycle count/4.
REQ-033 ch0 D=6, write ch0 D=2 on the edge its cnt=5 -> no tick that edge, clk_out[0]=0, ticks then every 2 cycles; wr_ch=5 (out of range) write -> no change on any channel.
REQ-034 Write D=0 to ch3 with en high -> tick[3]=0, clk_out[3] constant for 50 cycles; write D=1 -> tick[3] high every cycle.
REQ-035 Assert rst for 1 cycle mid-count with wr_en=1 -> all outputs 0, armed=4'b1111, div=DEF_DIV, write discarded.
